matrix_stream_reader: RTL and testbench

- Read-side client of the multi-matrix store.
- On a start request for one scale (rows x cols), queries the store for the number of matrices at that scale and fetches each one by local index 0..cnt-1.
- Snapshots each matrix and emits its elements one per handshake, row-major, on a valid/ready stream.
- Feeds the display/UART-TX formatting path. Separates the store's combinational parallel read from the serial consumers.

---
 rtl/matrix_stream_reader_pkg.sv | 33 +++
 rtl/matrix_stream_reader_if.sv | 35 +++
 rtl/matrix_snapshot_mux.sv | 29 ++
 rtl/matrix_stream_reader.sv | 133 +++++++++++++
 tb/tb_matrix_stream_reader.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_stream_reader_pkg.sv
// Shared definitions for the matrix store read path: sizes, reader FSM encoding
// and the dense row-major element layout used by both writer and reader.
package matrix_stream_reader_pkg;

    localparam int DATA_WIDTH          = 8;
    localparam int MAX_SIZE            = 5;
    localparam int MAX_MATRIX_PER_SIZE = 4;
    localparam int SEL_IDX_W           = 2;
    localparam int MEM_DEPTH           = MAX_SIZE * MAX_SIZE;
    localparam int ELEM_IDX_W          = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LOAD,
        S_STREAM,
        S_FIN
    } state_e;

    // Dense row-major position of (row, col) in a rows x cols matrix; max 24.
    function automatic logic [ELEM_IDX_W-1:0] elem_idx(input logic [2:0] row,
                                                       input logic [2:0] col,
                                                       input logic [2:0] cols);
        logic [ELEM_IDX_W-1:0] r5;
        logic [ELEM_IDX_W-1:0] c5;
        logic [ELEM_IDX_W-1:0] n5;
        r5 = {2'b00, row};
        c5 = {2'b00, col};
        n5 = {2'b00, cols};
        return r5 * n5 + c5;
    endfunction

endpackage

// File: rtl/matrix_stream_reader_if.sv
// Store query bus plus the element stream. The stream is valid/ready: a beat moves
// on a cycle where out_valid && out_ready; while out_valid && !out_ready all out_* hold.
interface matrix_stream_reader_if;
    import matrix_stream_reader_pkg::*;

    logic [2:0]                      req_scale_row;
    logic [2:0]                      req_scale_col;
    logic [SEL_IDX_W-1:0]            req_idx;
    logic [SEL_IDX_W-1:0]            scale_matrix_cnt;
    logic                            matrix_valid;
    logic [MEM_DEPTH*DATA_WIDTH-1:0] matrix_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [SEL_IDX_W-1:0]  out_mat;
    logic [2:0]            out_r;
    logic [2:0]            out_c;
    logic                  out_eol;
    logic                  out_eom;
    logic                  out_last;

    modport master (
        output req_scale_row, req_scale_col, req_idx,
        output out_valid, out_data, out_mat, out_r, out_c, out_eol, out_eom, out_last,
        input  scale_matrix_cnt, matrix_valid, matrix_data, out_ready
    );

    modport slave (
        input  req_scale_row, req_scale_col, req_idx,
        input  out_valid, out_data, out_mat, out_r, out_c, out_eol, out_eom, out_last,
        output scale_matrix_cnt, matrix_valid, matrix_data, out_ready
    );

endinterface

// File: rtl/matrix_snapshot_mux.sv
// Holds a private copy of one matrix so the store may change while it streams out,
// and selects the element addressed by the reader's current position.
module matrix_snapshot_mux
    import matrix_stream_reader_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            load,
    input  logic [MEM_DEPTH*DATA_WIDTH-1:0] matrix_data,
    input  logic [ELEM_IDX_W-1:0]           idx,
    output logic [DATA_WIDTH-1:0]           data
);

    logic [DATA_WIDTH-1:0] snap_q [MEM_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) snap_q[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < MEM_DEPTH; i++) snap_q[i] <= matrix_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        data = '0;
        if (int'(idx) < MEM_DEPTH) data = snap_q[idx];
    end

endmodule

// File: rtl/matrix_stream_reader.sv
// Walks every matrix stored at one scale and streams its elements row-major,
// one per valid/ready handshake, from a per-matrix snapshot.
module matrix_stream_reader
    import matrix_stream_reader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [2:0]             scale_row,
    input  logic [2:0]             scale_col,
    output logic                   busy,
    output logic                   done,
    output logic                   err_empty,
    output state_e                 state_dbg,
    matrix_stream_reader_if.master bus
);

    state_e               state_q;
    logic [2:0]           row_q, col_q, r_q, c_q;
    logic [SEL_IDX_W-1:0] idx_q, cnt_q;
    logic                 valid_q, busy_q, done_q;
    logic                 scale_ok, eol, eom, last, hs, snap_load;
    logic [DATA_WIDTH-1:0] snap_data;

    assign scale_ok  = (row_q != 3'd0) && (row_q <= 3'(MAX_SIZE)) &&
                       (col_q != 3'd0) && (col_q <= 3'(MAX_SIZE));
    assign eol       = (c_q == col_q - 3'd1);
    assign eom       = eol && (r_q == row_q - 3'd1);
    assign last      = eom && (idx_q == cnt_q - SEL_IDX_W'(1));
    assign hs        = valid_q && bus.out_ready;
    assign snap_load = (state_q == S_LOAD) && bus.matrix_valid;

    // Decoded from the current state so the pulse lands in the CHECK/LOAD cycle itself.
    assign err_empty = ((state_q == S_CHECK) && (!scale_ok || bus.scale_matrix_cnt == '0)) ||
                       ((state_q == S_LOAD) && !bus.matrix_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= 3'd1;
            col_q   <= 3'd1;
            r_q     <= '0;
            c_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        row_q   <= scale_row;
                        col_q   <= scale_col;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!scale_ok || bus.scale_matrix_cnt == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q   <= bus.scale_matrix_cnt;
                        idx_q   <= '0;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!bus.matrix_valid) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        r_q     <= '0;
                        c_q     <= '0;
                        valid_q <= 1'b1;
                        state_q <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (hs) begin
                        if (last) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else if (eom) begin
                            // Dropping valid here is the single bubble while the next matrix loads.
                            valid_q <= 1'b0;
                            idx_q   <= idx_q + SEL_IDX_W'(1);
                            state_q <= S_LOAD;
                        end else if (eol) begin
                            c_q <= '0;
                            r_q <= r_q + 3'd1;
                        end else begin
                            c_q <= c_q + 3'd1;
                        end
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    matrix_snapshot_mux u_snapshot (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (snap_load),
        .matrix_data (bus.matrix_data),
        .idx         (elem_idx(r_q, c_q, col_q)),
        .data        (snap_data)
    );

    assign busy              = busy_q;
    assign done              = done_q;
    assign state_dbg         = state_q;
    assign bus.req_scale_row = row_q;
    assign bus.req_scale_col = col_q;
    assign bus.req_idx       = idx_q;
    assign bus.out_valid     = valid_q;
    assign bus.out_data      = snap_data;
    assign bus.out_mat       = idx_q;
    assign bus.out_r         = r_q;
    assign bus.out_c         = c_q;
    assign bus.out_eol       = valid_q && eol;
    assign bus.out_eom       = valid_q && eom;
    assign bus.out_last      = valid_q && last;

endmodule

// File: tb/tb_matrix_stream_reader.sv
// Bench for matrix_stream_reader: a behavioural store drives the query bus, and
// expected beats are generated from stored matrix contents in row-major order.
module tb_matrix_stream_reader;
    import matrix_stream_reader_pkg::*;

    localparam int BW = DATA_WIDTH + SEL_IDX_W + 3 + 3 + 3;

    // clock / reset
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] scale_row = 3'd0;
    logic [2:0] scale_col = 3'd0;
    logic       busy, done, err_empty;
    state_e     state_dbg;

    always #5 clk = ~clk;

    matrix_stream_reader_if bus ();

    matrix_stream_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .scale_row (scale_row),
        .scale_col (scale_col),
        .busy      (busy),
        .done      (done),
        .err_empty (err_empty),
        .state_dbg (state_dbg),
        .bus       (bus)
    );

    // behavioural store, answered combinationally from the requested scale/index
    logic [SEL_IDX_W-1:0]            cnt_tab [0:7][0:7];
    logic [MEM_DEPTH*DATA_WIDTH-1:0] mat_tab [0:7][0:7][0:3];

    always_comb begin
        bus.scale_matrix_cnt = cnt_tab[bus.req_scale_row][bus.req_scale_col];
        bus.matrix_valid     = (bus.req_idx < cnt_tab[bus.req_scale_row][bus.req_scale_col]);
        bus.matrix_data      = mat_tab[bus.req_scale_row][bus.req_scale_col][bus.req_idx];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_scale(input int rows, input int cols, input int n);
        cnt_tab[rows][cols] = 2'(n);
        for (int m = 0; m < 4; m++)
            for (int e = 0; e < MEM_DEPTH; e++)
                mat_tab[rows][cols][m][e*DATA_WIDTH +: DATA_WIDTH] = 8'($urandom_range(0, 255));
    endtask

    // One full run: builds the expected beat queue, then consumes the stream.
    task automatic do_run(input int rows, input int cols, input int ready_pct,
                          input bit mid_start, input bit mid_write);
        logic [BW-1:0] exp_q[$];
        logic [BW-1:0] obs, head;
        int n, cyc, first_valid, beats, bubbles;
        bit fin, pulsed, written;
        n = int'(cnt_tab[rows][cols]);
        for (int m = 0; m < n; m++)
            for (int r = 0; r < rows; r++)
                for (int c = 0; c < cols; c++) begin
                    logic eol, eom, lst;
                    eol = (c == cols - 1);
                    eom = eol && (r == rows - 1);
                    lst = eom && (m == n - 1);
                    exp_q.push_back({mat_tab[rows][cols][m][(r*cols+c)*DATA_WIDTH +: DATA_WIDTH],
                                     2'(m), 3'(r), 3'(c), eol, eom, lst});
                end

        @(negedge clk);
        scale_row = 3'(rows);
        scale_col = 3'(cols);
        start = 1'b1;
        cyc = 0; first_valid = -1; beats = 0; bubbles = 0;
        fin = 1'b0; pulsed = 1'b0; written = 1'b0;
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (mid_start && beats == 2 && !pulsed) begin
                start = 1'b1;
                scale_row = 3'd1;
                scale_col = 3'd1;
                pulsed = 1'b1;
            end
            if (mid_write && beats == 1 && !written) begin
                cnt_tab[rows][cols] = cnt_tab[rows][cols] + 2'd1;
                for (int e = 0; e < MEM_DEPTH; e++) begin
                    mat_tab[rows][cols][0][e*DATA_WIDTH +: DATA_WIDTH] = 8'($urandom_range(0, 255));
                    mat_tab[rows][cols][2][e*DATA_WIDTH +: DATA_WIDTH] = 8'($urandom_range(0, 255));
                end
                written = 1'b1;
            end
            if (cyc == 1) begin
                chk("busy_after_start", busy, 1);
                chk("no_valid_in_check", bus.out_valid, 0);
            end
            bus.out_ready = ($urandom_range(0, 99) < ready_pct);
            if (bus.out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                obs  = {bus.out_data, bus.out_mat, bus.out_r, bus.out_c,
                        bus.out_eol, bus.out_eom, bus.out_last};
                head = (exp_q.size() > 0) ? exp_q[0] : '1;
                chk("beat", 32'(obs), 32'(head));
                if (bus.out_ready) begin
                    beats++;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    fin = (exp_q.size() == 0);
                end
            end else if (first_valid >= 0) begin
                bubbles++;
            end
        end
        chk("run_complete", exp_q.size(), 0);
        chk("first_valid_latency", first_valid, 3);
        chk("beat_count", beats, n * rows * cols);
        if (ready_pct == 100) chk("bubbles", bubbles, n - 1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        chk("valid_after_last", bus.out_valid, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    task automatic do_err(input int rows, input int cols);
        @(negedge clk);
        scale_row = 3'(rows);
        scale_col = 3'(cols);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", err_empty, 1);
        chk("err_busy_in_check", busy, 1);
        chk("err_no_valid", bus.out_valid, 0);
        @(negedge clk);
        chk("err_one_cycle", err_empty, 0);
        chk("err_busy_low", busy, 0);
        chk("err_no_valid2", bus.out_valid, 0);
        chk("err_no_done", done, 0);
        @(negedge clk);
        chk("err_no_valid3", bus.out_valid, 0);
        chk("err_no_done2", done, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err_empty, 0);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_req_row"}, bus.req_scale_row, 1);
        chk({tag, "_req_col"}, bus.req_scale_col, 1);
        chk({tag, "_req_idx"}, bus.req_idx, 0);
        chk({tag, "_data"}, bus.out_data, 0);
        chk({tag, "_tags"}, {bus.out_r, bus.out_c, bus.out_eol, bus.out_eom, bus.out_last}, 0);
    endtask

    initial begin
        bus.out_ready = 1'b0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                cnt_tab[r][c] = '0;
                for (int m = 0; m < 4; m++) mat_tab[r][c][m] = '0;
            end

        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 2x3, two matrices, always ready
        fill_scale(2, 3, 2);
        do_run(2, 3, 100, 1'b0, 1'b0);

        // 5x5, largest count the index width holds, random back-pressure
        fill_scale(5, 5, 3);
        do_run(5, 5, 50, 1'b0, 1'b0);

        // empty scale and invalid scales
        fill_scale(3, 3, 0);
        do_err(3, 3);
        fill_scale(6, 1, 2);
        do_err(6, 1);
        fill_scale(0, 2, 1);
        do_err(0, 2);

        // start ignored mid-stream, store rewritten mid-run
        fill_scale(2, 2, 2);
        fill_scale(1, 1, 1);
        do_run(2, 2, 70, 1'b1, 1'b1);

        // reset in the middle of a stream
        fill_scale(3, 3, 2);
        @(negedge clk);
        scale_row = 3'd3;
        scale_col = 3'd3;
        start = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_streaming", bus.out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        repeat (3) begin
            @(negedge clk);
            chk("no_done_in_reset", done, 0);
        end
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        fill_scale(1, 1, 1);
        do_run(1, 1, 100, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
